// File: rtl/ring_out_arbiter.sv
// One-direction ring output arbiter: through-traffic vs. PE injection, VC time-multiplexed by polarity.
// Define RING_ARB_RR_EN for per-VC round-robin; otherwise ring always beats PE.
module ring_out_arbiter #(
   parameter int DW = 64
) (
   input  logic          i_clk,
   input  logic          i_reset,
   output logic          o_polarity,
   input  logic [1:0]    i_ring_req,
   input  logic [DW-1:0] i_ring_d0,
   input  logic [DW-1:0] i_ring_d1,
   input  logic [1:0]    i_pe_req,
   input  logic [DW-1:0] i_pe_d0,
   input  logic [DW-1:0] i_pe_d1,
   output logic [1:0]    o_ring_gnt,
   output logic [1:0]    o_pe_gnt,
   output logic          o_so,
   input  logic          i_ri,
   output logic [DW-1:0] o_do,
   output logic [15:0]   o_sent_cnt
);

   logic          r_pol;
   logic          r_so;
   logic [DW-1:0] r_do;
   logic [1:0]    r_ring_gnt;
   logic [1:0]    r_pe_gnt;
   logic [15:0]   r_sent_cnt;

   logic          w_ring_v;
   logic          w_pe_v;
   logic          w_grant;
   logic          w_pick_pe;
   logic [DW-1:0] w_ring_d;
   logic [DW-1:0] w_pe_d;

`ifdef RING_ARB_RR_EN
   // r_last[v]: previous VC v winner, 0 = ring, 1 = PE
   logic [1:0]    r_last;
`endif

   always_comb begin
      w_ring_v = i_ring_req[r_pol];
      w_pe_v   = i_pe_req[r_pol];
      w_ring_d = r_pol ? i_ring_d1 : i_ring_d0;
      w_pe_d   = r_pol ? i_pe_d1 : i_pe_d0;
      w_grant  = i_ri & (w_ring_v | w_pe_v);
`ifdef RING_ARB_RR_EN
      w_pick_pe = w_pe_v & (~w_ring_v | ~r_last[r_pol]);
`else
      w_pick_pe = w_pe_v & ~w_ring_v;
`endif
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pol      <= 1'b0;
         r_so       <= 1'b0;
         r_do       <= '0;
         r_ring_gnt <= 2'b00;
         r_pe_gnt   <= 2'b00;
         r_sent_cnt <= 16'd0;
      end else begin
         r_pol      <= ~r_pol;
         r_so       <= w_grant;
         r_ring_gnt <= 2'b00;
         r_pe_gnt   <= 2'b00;
         if (w_grant) begin
            r_do       <= w_pick_pe ? w_pe_d : w_ring_d;
            r_sent_cnt <= r_sent_cnt + 16'd1;
            if (w_pick_pe)
               r_pe_gnt[r_pol] <= 1'b1;
            else
               r_ring_gnt[r_pol] <= 1'b1;
         end
      end
   end

`ifdef RING_ARB_RR_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_last <= 2'b11;
      else if (w_grant)
         r_last[r_pol] <= w_pick_pe;
   end
`endif

   assign o_polarity = r_pol;
   assign o_so       = r_so;
   assign o_do       = r_do;
   assign o_ring_gnt = r_ring_gnt;
   assign o_pe_gnt   = r_pe_gnt;
   assign o_sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_ring_out_arbiter.sv
// Directed-vector bench for ring_out_arbiter; honours RING_ARB_RR_EN like the design.
module tb_ring_out_arbiter;

`ifdef RING_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        pol;
   logic [1:0]  ring_req;
   logic [63:0] ring_d0;
   logic [63:0] ring_d1;
   logic [1:0]  pe_req;
   logic [63:0] pe_d0;
   logic [63:0] pe_d1;
   logic [1:0]  ring_gnt;
   logic [1:0]  pe_gnt;
   logic        so;
   logic        ri;
   logic [63:0] link_d;
   logic [15:0] sent_cnt;

   int n_vec;
   int n_err;

   ring_out_arbiter #(.DW(64)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .o_polarity (pol),
      .i_ring_req (ring_req),
      .i_ring_d0  (ring_d0),
      .i_ring_d1  (ring_d1),
      .i_pe_req   (pe_req),
      .i_pe_d0    (pe_d0),
      .i_pe_d1    (pe_d1),
      .o_ring_gnt (ring_gnt),
      .o_pe_gnt   (pe_gnt),
      .o_so       (so),
      .i_ri       (ri),
      .o_do       (link_d),
      .o_sent_cnt (sent_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #3 rst = 1'b0;
   endtask

   task automatic chk_idle(input string tag, input logic [15:0] cnt);
      chk({tag, "_so"}, so, 1'b0);
      chk({tag, "_rgnt"}, ring_gnt, 2'b00);
      chk({tag, "_pgnt"}, pe_gnt, 2'b00);
      chk({tag, "_cnt"}, sent_cnt, cnt);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      ring_req = 2'b00; pe_req = 2'b00; ri = 1'b1;
      ring_d0 = 64'h0; ring_d1 = 64'h0; pe_d0 = 64'h0; pe_d1 = 64'h0;

      // reset state
      #3;
      chk("rst_pol", pol, 1'b0);
      chk("rst_do", link_d, 64'h0);
      chk_idle("rst", 16'd0);
      #9 rst = 1'b0;

      // idle polarity toggling
      chk("idle_pol0", pol, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("idle_pol", pol, 64'(i % 2));
         chk_idle("idle", 16'd0);
      end

      // single ring request on VC0
      ring_req = 2'b01; ring_d0 = 64'hA5;
      step();
      ring_req = 2'b00;
      chk("one_so", so, 1'b1);
      chk("one_do", link_d, 64'hA5);
      chk("one_rgnt", ring_gnt, 2'b01);
      chk("one_pgnt", pe_gnt, 2'b00);
      chk("one_cnt", sent_cnt, 16'd1);
      step();
      chk_idle("one_after", 16'd1);
      chk("one_hold_do", link_d, 64'hA5);

      // VC0 contention from fresh reset
      do_reset();
      chk("c_rst_cnt", sent_cnt, 16'd0);
      ring_req = 2'b01; pe_req = 2'b01;
      ring_d0 = 64'h1111_0000_0000_0001; pe_d0 = 64'h2222_0000_0000_0002;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k % 2 == 0) begin
            automatic bit pe_win = RR && ((k / 2) % 2 == 1);
            chk("cont_so", so, 1'b1);
            chk("cont_rgnt", ring_gnt, pe_win ? 2'b00 : 2'b01);
            chk("cont_pgnt", pe_gnt, pe_win ? 2'b01 : 2'b00);
            chk("cont_do", link_d, pe_win ? 64'h2222_0000_0000_0002 : 64'h1111_0000_0000_0001);
         end else begin
            chk("cont_so_odd", so, 1'b0);
            chk("cont_gnt_odd", {ring_gnt, pe_gnt}, 4'b0000);
         end
      end
      chk("cont_cnt", sent_cnt, 16'd4);

      // PE on both VCs: one packet per cycle, alternating VC
      ring_req = 2'b00; pe_req = 2'b11;
      pe_d0 = 64'hD0D0_D0D0_0000_0000; pe_d1 = 64'hD1D1_D1D1_1111_1111;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("pe2_so", so, 1'b1);
         chk("pe2_pgnt", pe_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
         chk("pe2_rgnt", ring_gnt, 2'b00);
         chk("pe2_do", link_d, (k % 2 == 0) ? 64'hD0D0_D0D0_0000_0000 : 64'hD1D1_D1D1_1111_1111);
         chk("pe2_cnt", sent_cnt, 64'(5 + k));
      end

      // ri backpressure
      pe_req = 2'b00; ring_req = 2'b11; ri = 1'b0;
      ring_d0 = 64'hCAFE_0000; ring_d1 = 64'hBEEF_1111;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_idle("ri0", 16'd8);
      end
      chk("ri_pol", pol, 1'b1);
      ri = 1'b1;
      step();
      chk("ri1_so", so, 1'b1);
      chk("ri1_rgnt", ring_gnt, 2'b10);
      chk("ri1_do", link_d, 64'hBEEF_1111);
      chk("ri1_cnt", sent_cnt, 16'd9);

      // async reset mid-packet
      ring_req = 2'b00; pe_req = 2'b11;
      step();
      chk("mid_pgnt0", pe_gnt, 2'b01);
      step();
      chk("mid_pgnt1", pe_gnt, 2'b10);
      chk("mid_so", so, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_do", link_d, 64'h0);
      chk("arst_pol", pol, 1'b0);
      chk_idle("arst", 16'd0);
      #2 rst = 1'b0;
      step();
      chk("post_pgnt", pe_gnt, 2'b01);
      chk("post_pol", pol, 1'b1);
      chk("post_cnt", sent_cnt, 16'd1);

      // sent_cnt wrap
      for (int k = 0; k < 65534; k++) step();
      chk("wrap_ffff", sent_cnt, 16'hFFFF);
      step();
      chk("wrap_0", sent_cnt, 16'h0000);
      chk("wrap_so", so, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
